// File: rtl/tick_event_scheduler.sv
// Turns PULSE_5MS ticks into timestamped, sequence-numbered events queued in a FWFT FIFO.
// Define TICK_EVENT_SCHEDULER_SKEW_CHECK_EN to build the inter-event skew check.
module tick_event_scheduler #(
  parameter int unsigned PERIOD_TICKS  = 200,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CLKS_PER_TICK = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enable,
  input  logic [31:0] system_time,
  input  logic        pulse_5ms,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [31:0] evt_timestamp,
  output logic [15:0] evt_seq,
  output logic [7:0]  overflow_count,
  output logic        busy,
  output logic        skew_err
);

  localparam int unsigned     PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [15:0]     LastTick = 16'(PERIOD_TICKS - 1);
  localparam logic [CntW-1:0] Depth    = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic        clear;
  logic        resume;
  logic        tick_hit;
  logic        gen_evt;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] seq_cnt_q, seq_cnt_d;

  logic [31:0]     mem_ts  [FIFO_DEPTH];
  logic [15:0]     mem_seq [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop, drop;
  logic [31:0]     hold_ts_q;
  logic [15:0]     hold_seq_q;
  logic [7:0]      overflow_q;

  assign clear = reset | start;

  // Scheduler FSM
  always_comb begin
    state_d = state_q;
    resume  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          resume  = 1'b1;
        end
      end
      StRun: begin
        if (!enable) state_d = StDrain;
      end
      StDrain: begin
        if (enable) begin
          state_d = StRun;
          resume  = 1'b1;
        end else if (fifo_empty) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pulses only count in RUN; tick_cnt is held across DRAIN and IDLE.
  assign tick_hit = (state_q == StRun) && pulse_5ms;
  assign gen_evt  = tick_hit && (tick_cnt_q == LastTick);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_hit) begin
      tick_cnt_d = gen_evt ? 16'd0 : tick_cnt_q + 16'd1;
    end
  end

  assign seq_cnt_d = gen_evt ? seq_cnt_q + 16'd1 : seq_cnt_q;

  // Event FIFO; a full FIFO still accepts a push when the head pops in the same cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == Depth);
  assign pop        = !fifo_empty && evt_ready;
  assign push       = gen_evt && (!fifo_full || pop);
  assign drop       = gen_evt && fifo_full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ts[wr_ptr_q]  <= system_time;
      mem_seq[wr_ptr_q] <= seq_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      seq_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_ts_q  <= '0;
      hold_seq_q <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      seq_cnt_q  <= seq_cnt_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        // Keep the departing head so the data outputs hold once the FIFO runs dry.
        hold_ts_q  <= mem_ts[rd_ptr_q];
        hold_seq_q <= mem_seq[rd_ptr_q];
      end
      if (drop && (overflow_q != 8'hFF)) overflow_q <= overflow_q + 8'd1;
    end
  end

  assign evt_valid      = !fifo_empty;
  assign evt_timestamp  = fifo_empty ? hold_ts_q : mem_ts[rd_ptr_q];
  assign evt_seq        = fifo_empty ? hold_seq_q : mem_seq[rd_ptr_q];
  assign overflow_count = overflow_q;
  assign busy           = (state_q != StIdle);

`ifdef TICK_EVENT_SCHEDULER_SKEW_CHECK_EN
  localparam logic [31:0] ExpDelta = 32'(PERIOD_TICKS * CLKS_PER_TICK);

  logic [31:0] last_time_q;
  logic        skip_q;
  logic        skew_q;

  // The first event after a (re)start or resume only seeds last_time_q.
  always_ff @(posedge clk) begin
    if (clear) begin
      last_time_q <= '0;
      skip_q      <= 1'b1;
      skew_q      <= 1'b0;
    end else begin
      if (resume) skip_q <= 1'b1;
      if (gen_evt) begin
        last_time_q <= system_time;
        skip_q      <= 1'b0;
        if (!skip_q && ((system_time - last_time_q) != ExpDelta)) skew_q <= 1'b1;
      end
    end
  end

  assign skew_err = skew_q;
`else
  logic unused_clks_per_tick;
  assign unused_clks_per_tick = ^32'(CLKS_PER_TICK);
  assign skew_err = 1'b0;
`endif

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Self-checking bench for tick_event_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based reference model.
module tb_tick_event_scheduler;

  localparam int unsigned P = 3;
  localparam int unsigned D = 4;
  localparam int unsigned C = 10;

  logic        clk = 1'b0;
  logic        reset, start, enable, pulse_5ms, evt_ready;
  logic [31:0] system_time;
  logic        evt_valid, busy, skew_err;
  logic [31:0] evt_timestamp;
  logic [15:0] evt_seq;
  logic [7:0]  overflow_count;

  always #5 clk = ~clk;

  tick_event_scheduler #(
    .PERIOD_TICKS (P),
    .FIFO_DEPTH   (D),
    .CLKS_PER_TICK(C)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .enable        (enable),
    .system_time   (system_time),
    .pulse_5ms     (pulse_5ms),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_timestamp (evt_timestamp),
    .evt_seq       (evt_seq),
    .overflow_count(overflow_count),
    .busy          (busy),
    .skew_err      (skew_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pending events plus plain counters.
  typedef struct packed {
    logic [31:0] ts;
    logic [15:0] seq;
  } evt_t;

  evt_t        q[$];
  int          m_mode = 0;  // 0 idle, 1 running, 2 draining
  int unsigned m_ticks = 0;
  logic [15:0] m_seq = '0;
  int          m_ovf = 0;
  logic [31:0] m_hold_ts = '0;
  logic [15:0] m_hold_seq = '0;
  bit          m_skew = 1'b0;
  bit          m_skip = 1'b1;
  logic [31:0] m_last = '0;
  int unsigned now = 0;

  typedef struct {
    int rs, st, en, pu, rdy;
    int ev, es, eb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit   was_empty, gen;
    evt_t e;
    if (reset || start) begin
      q.delete();
      m_mode = 0; m_ticks = 0; m_seq = '0; m_ovf = 0;
      m_hold_ts = '0; m_hold_seq = '0; m_skew = 1'b0; m_skip = 1'b1; m_last = '0;
      return;
    end
    was_empty = (q.size() == 0);
    gen = (m_mode == 1) && pulse_5ms && (m_ticks == P - 1);
    if (m_mode == 1 && pulse_5ms) m_ticks = (m_ticks + 1) % P;
    if (!was_empty && evt_ready) begin
      e = q.pop_front();
      m_hold_ts = e.ts;
      m_hold_seq = e.seq;
    end
    if (gen) begin
      if (q.size() < D) begin
        e.ts = system_time;
        e.seq = m_seq;
        q.push_back(e);
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
`ifdef TICK_EVENT_SCHEDULER_SKEW_CHECK_EN
      if (m_skip) m_skip = 1'b0;
      else if ((system_time - m_last) != 32'(P * C)) m_skew = 1'b1;
      m_last = system_time;
`endif
      m_seq = m_seq + 16'd1;
    end
    case (m_mode)
      0: if (enable) begin m_mode = 1; m_skip = 1'b1; end
      1: if (!enable) m_mode = 2;
      default: begin
        if (enable) begin m_mode = 1; m_skip = 1'b1; end
        else if (was_empty) m_mode = 0;
      end
    endcase
  endfunction

  task automatic compare_model();
    bit v;
    v = (q.size() > 0);
    chk("evt_valid", 32'(evt_valid), 32'(v));
    chk("evt_timestamp", evt_timestamp, v ? q[0].ts : m_hold_ts);
    chk("evt_seq", 32'(evt_seq), 32'(v ? q[0].seq : m_hold_seq));
    chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("skew_err", 32'(skew_err), 32'(m_skew));
  endtask

  // One clock: drive inputs after the falling edge, check 1 time unit after the rising edge.
  task automatic cycle(input int rs, input int st, input int en, input int pu, input int rdy);
    reset = (rs != 0); start = (st != 0); enable = (en != 0);
    pulse_5ms = (pu != 0); evt_ready = (rdy != 0);
    system_time = now;
    now++;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic add_vec(input int rs, input int st, input int en, input int pu, input int rdy,
                         input int ev, input int es, input int eb);
    vec_t v;
    v.rs = rs; v.st = st; v.en = en; v.pu = pu; v.rdy = rdy;
    v.ev = ev; v.es = es; v.eb = eb;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] ts_seen[$];
    logic [15:0] seq_seen[$];
    int          en_r;

    //       rs st en pu rdy  valid seq busy
    add_vec(1, 0, 0, 0, 0,   0, 0, 0);
    add_vec(0, 0, 1, 1, 1,   0, 0, 1);  // pulse on IDLE->RUN is ignored
    add_vec(0, 0, 1, 1, 1,   0, 0, 1);
    add_vec(0, 0, 1, 1, 1,   0, 0, 1);
    add_vec(0, 0, 1, 1, 1,   1, 0, 1);  // third counted pulse -> event 0
    add_vec(0, 0, 1, 0, 1,   0, 0, 1);  // popped, data holds
    add_vec(0, 0, 1, 1, 0,   0, 0, 1);
    add_vec(0, 0, 1, 1, 0,   0, 0, 1);
    add_vec(0, 0, 1, 1, 0,   1, 1, 1);
    add_vec(0, 0, 1, 0, 0,   1, 1, 1);  // stalled head is stable
    add_vec(0, 0, 0, 0, 0,   1, 1, 1);  // -> DRAIN
    add_vec(0, 0, 0, 1, 0,   1, 1, 1);
    add_vec(0, 0, 0, 0, 1,   0, 1, 1);
    add_vec(0, 0, 0, 0, 0,   0, 1, 0);  // empty -> IDLE
    add_vec(0, 0, 0, 1, 1,   0, 1, 0);
    add_vec(0, 1, 0, 0, 0,   0, 0, 0);  // START clears everything

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rs, vecs[i].st, vecs[i].en, vecs[i].pu, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_seq", i), 32'(evt_seq), 32'(vecs[i].es));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_count), 32'd0);
    end

    // Basic timing: pulses every 10 cycles, downstream always ready.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1);
    for (int k = 0; k < 90; k++) begin
      cycle(0, 0, 1, int'(k % 10 == 9), 1);
      if (evt_valid) begin
        ts_seen.push_back(evt_timestamp);
        seq_seen.push_back(evt_seq);
      end
    end
    chk("basic_valid_cycles", 32'(ts_seen.size()), 32'd3);
    if (ts_seen.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("basic_seq", 32'(seq_seen[i]), 32'(i));
      chk("basic_dt01", ts_seen[1] - ts_seen[0], 32'd30);
      chk("basic_dt12", ts_seen[2] - ts_seen[1], 32'd30);
    end

    // Overflow: 6 events into a 4-deep FIFO with the consumer stalled.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < 18; k++) cycle(0, 0, 1, 1, 0);
    chk("ovf_count", 32'(overflow_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_valid", 32'(evt_valid), 32'd1);
      chk("ovf_drain_seq", 32'(evt_seq), 32'(i));
      cycle(0, 0, 1, 0, 1);
    end
    chk("ovf_empty", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 0);
    chk("ovf_gap_seq", 32'(evt_seq), 32'd6);

    // Full with pop: fill to 4 (6..9), then a generating pulse coincides with a pop.
    for (int k = 0; k < 9; k++) cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 1);
    chk("fullpop_ovf", 32'(overflow_count), 32'd2);
    chk("fullpop_head", 32'(evt_seq), 32'd7);
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_valid", 32'(evt_valid), 32'd1);
      chk("fullpop_seq", 32'(evt_seq), 32'(7 + i));
      cycle(0, 0, 1, 0, 1);
    end
    chk("fullpop_empty", 32'(evt_valid), 32'd0);

    // Drain: two queued events keep BUSY high until both leave.
    for (int k = 0; k < 6; k++) cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_seq", 32'(evt_seq), 32'd11);
    cycle(0, 0, 0, 1, 1);
    chk("drain_busy1", 32'(busy), 32'd1);
    cycle(0, 0, 0, 1, 1);
    chk("drain_busy2", 32'(busy), 32'd1);
    chk("drain_empty", 32'(evt_valid), 32'd0);
    cycle(0, 0, 0, 1, 0);
    chk("drain_idle", 32'(busy), 32'd0);

    // Restart with three queued events.
    cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < 9; k++) cycle(0, 0, 1, 1, 0);
    cycle(0, 1, 1, 0, 0);
    chk("restart_valid", 32'(evt_valid), 32'd0);
    chk("restart_ovf", 32'(overflow_count), 32'd0);
    cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 0);
    chk("restart_seq", 32'(evt_seq), 32'd0);
    chk("restart_valid2", 32'(evt_valid), 32'd1);

    // Skew: spacing 10 then 11 cycles per pulse.
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    for (int k = 0; k < 30; k++) cycle(0, 0, 1, int'(k % 10 == 9), 1);
    chk("skew_first", 32'(skew_err), 32'd0);
    for (int k = 0; k < 33; k++) cycle(0, 0, 1, int'(k % 11 == 10), 1);
`ifdef TICK_EVENT_SCHEDULER_SKEW_CHECK_EN
    chk("skew_set", 32'(skew_err), 32'd1);
`else
    chk("skew_tied", 32'(skew_err), 32'd0);
`endif
    for (int k = 0; k < 20; k++) cycle(0, 0, 1, int'(k % 10 == 9), 1);
    cycle(0, 1, 0, 0, 1);
    chk("skew_cleared", 32'(skew_err), 32'd0);

    // Saturation of the overflow counter.
    cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < 800; k++) cycle(0, 0, 1, 1, 0);
    chk("ovf_saturate", 32'(overflow_count), 32'd255);

    // Randomized traffic against the model.
    cycle(1, 0, 0, 0, 0);
    en_r = 1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) en_r = 1 - en_r;
      cycle(int'($urandom_range(0, 499) == 0), int'($urandom_range(0, 499) == 0), en_r,
            int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
